spi_slave_proto_chk: RTL

Synthesizable, parametrised protocol checker for the SPI slave. It binds alongside the slave and observes MOSI, SS_n, rx_valid, rx_data, tx_valid, tx_data and MISO. It tracks each SS_n frame with an FSM and checks the following, reporting each as a sticky error bit plus counters for the env scoreboard and coverage:
- reset values
- rx framing, rx data and rx latency
- read-data turnaround and MISO serialization

---
 rtl/spi_slave_proto_chk.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_proto_chk.sv
// Protocol checker that sits beside the SPI slave and flags framing, rx, tx-turnaround and MISO errors.
// Optional macro SPI_CHK_CMD_ORDER_EN adds read-data-after-read-address ordering check (err_vec[7]).
module spi_slave_proto_chk #(
  parameter int DATA_W = 8,
  parameter int RX_LAT = 2,
  parameter int TX_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MOSI,
  input  logic              SS_n,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] rx_data,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              MISO,
  output logic [7:0]        err_vec,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  frame_count,
  output logic              busy
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int BCNT_W  = $clog2(FRAME_W + 1);
  localparam int SCNT_W  = $clog2(DATA_W + 1);
  localparam int MAX_LAT = (RX_LAT > TX_LAT) ? RX_LAT : TX_LAT;
  localparam int TMR_W   = $clog2(MAX_LAT + 2);

  localparam int E_RST    = 0;
  localparam int E_RXDATA = 1;
  localparam int E_RXTO   = 2;
  localparam int E_SPUR   = 3;
  localparam int E_MISO   = 4;
  localparam int E_EARLY  = 5;
  localparam int E_TXTO   = 6;
  localparam int E_ORDER  = 7;

  typedef enum logic [2:0] {
    IDLE, SHIFT, WAIT_RX, WAIT_TX, SERIAL, END
  } state_t;

  state_t               state, state_n;
  logic [FRAME_W-1:0]   exp_frame, exp_frame_n;
  logic [BCNT_W-1:0]    bcnt, bcnt_n;
  logic [TMR_W-1:0]     tmr, tmr_n;
  logic [SCNT_W-1:0]    scnt, scnt_n;
  logic [DATA_W-1:0]    tx_sh, tx_sh_n;
  logic [7:0]           err_now;
  logic                 any_err;
  logic                 post_rst;
  logic                 frame_err;
  logic                 frame_done;

`ifdef SPI_CHK_CMD_ORDER_EN
  logic [1:0]           last_cmd;
  logic                 rx_good;
`endif

  assign busy    = (state != IDLE);
  assign any_err = |err_now;

  always_comb begin
    state_n     = state;
    exp_frame_n = exp_frame;
    bcnt_n      = bcnt;
    tmr_n       = tmr;
    scnt_n      = scnt;
    tx_sh_n     = tx_sh;
    err_now     = '0;
`ifdef SPI_CHK_CMD_ORDER_EN
    rx_good     = 1'b0;
`endif

    if (post_rst && (rx_valid || (|rx_data) || MISO))
      err_now[E_RST] = 1'b1;
    if (rx_valid && (state != WAIT_RX))
      err_now[E_SPUR] = 1'b1;

    case (state)
      IDLE: begin
        if (!SS_n) begin
          state_n = SHIFT;
          bcnt_n  = '0;
        end
      end
      SHIFT: begin
        if (SS_n) begin
          err_now[E_EARLY] = 1'b1;
          state_n          = IDLE;
        end else begin
          exp_frame_n = {exp_frame[FRAME_W-2:0], MOSI};
          bcnt_n      = bcnt + 1'b1;
          if (bcnt == BCNT_W'(FRAME_W - 1)) begin
            state_n = WAIT_RX;
            tmr_n   = '0;
          end
        end
      end
      // tmr+1 is the latency of the current edge; a strobe on the first late edge is already a timeout
      WAIT_RX: begin
        tmr_n = tmr + 1'b1;
        if (int'(tmr) >= RX_LAT) begin
          err_now[E_RXTO] = 1'b1;
          state_n         = END;
        end else if (rx_valid) begin
          if (rx_data != exp_frame)
            err_now[E_RXDATA] = 1'b1;
`ifdef SPI_CHK_CMD_ORDER_EN
          else
            rx_good = 1'b1;
          if ((rx_data == exp_frame) && (exp_frame[FRAME_W-1:FRAME_W-2] == 2'b11) &&
              (last_cmd != 2'b10))
            err_now[E_ORDER] = 1'b1;
`endif
          if (exp_frame[FRAME_W-1:FRAME_W-2] == 2'b11) begin
            state_n = WAIT_TX;
            tmr_n   = '0;
          end else begin
            state_n = END;
          end
        end
      end
      WAIT_TX: begin
        tmr_n = tmr + 1'b1;
        if (SS_n) begin
          err_now[E_EARLY] = 1'b1;
          state_n          = IDLE;
        end else if (int'(tmr) >= TX_LAT) begin
          err_now[E_TXTO] = 1'b1;
          state_n         = END;
        end else if (tx_valid) begin
          tx_sh_n = tx_data;
          scnt_n  = '0;
          state_n = SERIAL;
        end
      end
      SERIAL: begin
        if (SS_n) begin
          err_now[E_EARLY] = 1'b1;
          state_n          = IDLE;
        end else begin
          if (MISO != tx_sh[DATA_W-1])
            err_now[E_MISO] = 1'b1;
          tx_sh_n = tx_sh << 1;
          scnt_n  = scnt + 1'b1;
          if (scnt == SCNT_W'(DATA_W - 1))
            state_n = END;
        end
      end
      END: begin
        if (SS_n)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // a frame counts only if it arrives in END without any error raised since it left IDLE
  assign frame_done = (state_n == END) && (state != END) && !frame_err && !any_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      exp_frame   <= '0;
      bcnt        <= '0;
      tmr         <= '0;
      scnt        <= '0;
      tx_sh       <= '0;
      post_rst    <= 1'b1;
      frame_err   <= 1'b0;
      err_vec     <= '0;
      err_count   <= '0;
      frame_count <= '0;
    end else begin
      state       <= state_n;
      exp_frame   <= exp_frame_n;
      bcnt        <= bcnt_n;
      tmr         <= tmr_n;
      scnt        <= scnt_n;
      tx_sh       <= tx_sh_n;
      post_rst    <= 1'b0;
      frame_err   <= ((state == IDLE) ? 1'b0 : frame_err) | any_err;
      err_vec     <= err_vec | err_now;
      if (any_err && !(&err_count))
        err_count <= err_count + 1'b1;
      if (frame_done && !(&frame_count))
        frame_count <= frame_count + 1'b1;
    end
  end

`ifdef SPI_CHK_CMD_ORDER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_cmd <= 2'b00;
    else if (rx_good)
      last_cmd <= exp_frame[FRAME_W-1:FRAME_W-2];
  end
`endif

endmodule
